// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states, defaults.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_ITER  = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Multi-cycle ops (mult/multu/div/divu) all have op[2] clear.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  // Signed variants are the even encodings of the arithmetic group.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on {acc_hi, acc_lo}.
module muldiv_step import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] acc_hi_c_o,
  output logic [WIDTH-1:0] acc_lo_c_o
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  // Multiply: add multiplicand on LSB of multiplier, shift {carry,hi,lo} right.
  // Divide: shift next dividend bit into remainder, keep trial difference if non-negative.
  always_comb begin
    acc_hi_c_o = acc_hi_i;
    acc_lo_c_o = acc_lo_i;
    mul_sum    = (WIDTH+1)'(acc_hi_i) + (acc_lo_i[0] ? (WIDTH+1)'(operand_i) : (WIDTH+1)'(0));
    div_shift  = {acc_hi_i, acc_lo_i[WIDTH-1]};
    div_diff   = div_shift - {1'b0, operand_i};
    if (is_div_i) begin
      if (!div_diff[WIDTH]) begin
        acc_hi_c_o = div_diff[WIDTH-1:0];
        acc_lo_c_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_c_o = div_shift[WIDTH-1:0];
        acc_lo_c_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_c_o = mul_sum[WIDTH:1];
      acc_lo_c_o = {mul_sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide unit: FSM, iteration counter, sign fix-up, HI/LO.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ITER  = DEF_ITER
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_q, div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_hi_c, step_lo_c;
  logic               sgn_a_c, sgn_b_c;
  logic [WIDTH-1:0]   abs_a_c, abs_b_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quo_c, rem_c;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i   (div_q),
    .acc_hi_i   (acc_hi_q),
    .acc_lo_i   (acc_lo_q),
    .operand_i  (opnd_q),
    .acc_hi_c_o (step_hi_c),
    .acc_lo_c_o (step_lo_c)
  );

  // Operand magnitudes and sign flags captured when a request is accepted.
  always_comb begin
    sgn_a_c = is_signed_op(bus.op) && bus.a[WIDTH-1];
    sgn_b_c = is_signed_op(bus.op) && bus.b[WIDTH-1];
    abs_a_c = sgn_a_c ? (WIDTH'(~bus.a) + WIDTH'(1)) : bus.a;
    abs_b_c = sgn_b_c ? (WIDTH'(~bus.b) + WIDTH'(1)) : bus.b;
  end

  // Sign correction of the unsigned iteration result; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_c = {acc_hi_q, acc_lo_q};
    quo_c  = acc_lo_q;
    rem_c  = acc_hi_q;
    if (neg_a_q ^ neg_b_q) begin
      prod_c = (2*WIDTH)'(~prod_c) + (2*WIDTH)'(1);
      quo_c  = WIDTH'(~acc_lo_q) + WIDTH'(1);
    end
    if (neg_a_q) begin
      rem_c = WIDTH'(~acc_hi_q) + WIDTH'(1);
    end
    if (dz_q) begin
      quo_c = '1;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_d    = div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (is_arith_op(bus.op)) begin
            state_d  = ST_CALC;
            cnt_d    = '0;
            div_d    = is_div_op(bus.op);
            neg_a_d  = sgn_a_c;
            neg_b_d  = sgn_b_c;
            dz_d     = is_div_op(bus.op) && (bus.b == '0);
            acc_hi_d = '0;
            // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier out.
            if (is_div_op(bus.op)) begin
              acc_lo_d = abs_a_c;
              opnd_d   = abs_b_c;
            end else begin
              acc_lo_d = abs_b_c;
              opnd_d   = abs_a_c;
            end
          end else if (bus.op == OP_MTHI) begin
            hi_d = bus.a;
          end else if (bus.op == OP_MTLO) begin
            lo_d = bus.a;
          end
        end
      end
      ST_CALC: begin
        acc_hi_d = step_hi_c;
        acc_lo_d = step_lo_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (div_q) begin
          hi_d = rem_c;
          lo_d = quo_c;
        end else begin
          hi_d = prod_c[2*WIDTH-1:WIDTH];
          lo_d = prod_c[WIDTH-1:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: drop the operation without touching HI/LO.
    if (bus.flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized checks of muldiv_ctrl against an arithmetic HI/LO reference model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int unsigned W        = 32;
  localparam int unsigned ITER     = 32;
  localparam int          BUSY_CYC = ITER + 2;

  logic clk = 1'b0;
  logic reset;

  muldiv_if #(.WIDTH(W)) bus();

  muldiv_ctrl #(.WIDTH(W), .ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: architectural HI/LO effect of one op, from plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin m_lo = '1; m_hi = a; end
        else begin
          sp = sa / sb; m_lo = sp[31:0];
          sp = sa % sb; m_hi = sp[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one multi-cycle op; optionally poke a second request while busy.
  task automatic run_arith(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit poke);
    int n, busy_n, done_n, done_at;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    model(op, a, b);
    n = 0; busy_n = 0; done_n = 0; done_at = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) busy_n++;
      if (bus.done) begin done_n++; done_at = n; end
      if (n == 1) begin bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; end
      if (n == 3 && poke) begin bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF; end
      if (n == 5 && poke) begin bus.start = 1'b1; bus.op = 3'd1; bus.b = 32'h1234_5678; end
      if (n == 6) bus.start = 1'b0;
    end while ((bus.busy || n < 2) && n < 100);
    check({tag, "_timeout"}, 64'(n < 100), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(BUSY_CYC));
    check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    check({tag, "_done_cycle"}, 64'(done_at), 64'(BUSY_CYC));
    check({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
  endtask

  // Single-cycle requests (mthi/mtlo/undefined), optionally colliding with flush.
  task automatic run_move(input string tag, input logic [2:0] op, input logic [31:0] a, input bit fl);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.flush = fl;
    if (!fl) model(op, a, 32'd0);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, done_n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed corner cases with hand-computed results.
    run_arith("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_max_lo_const", 64'(bus.lo), 64'h0000_0001);
    run_arith("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
    check("mult_neg_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_neg_lo_const", 64'(bus.lo), 64'hFFFF_FFF1);
    run_arith("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_neg_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    run_arith("divu_zero", OP_DIVU, 32'd100, 32'd0, 1'b0);
    check("divu_zero_lo_const", 64'(bus.lo), 64'hFFFF_FFFF);
    check("divu_zero_hi_const", 64'(bus.hi), 64'd100);
    run_arith("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo_const", 64'(bus.lo), 64'h8000_0000);
    check("div_ovf_hi_const", 64'(bus.hi), 64'd0);
    run_arith("div_neg_zero", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);

    run_move("mthi", OP_MTHI, 32'h1234_5678, 1'b0);
    check("mthi_hi_const", 64'(bus.hi), 64'h1234_5678);
    run_move("mtlo", OP_MTLO, 32'hCAFE_F00D, 1'b0);
    run_move("undef6", 3'd6, 32'h5555_AAAA, 1'b0);
    run_move("undef7", 3'd7, 32'hAAAA_5555, 1'b0);
    run_move("flush_mthi", OP_MTHI, 32'h0BAD_0BAD, 1'b1);

    // Flush mid-multiply: HI/LO untouched, no done, busy drops the next cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd7; bus.b = 32'd9;
    done_n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
      if (i == 1) bus.start = 1'b0;
      if (i == 3) begin bus.start = 1'b1; bus.op = OP_DIVU; end
      if (i == 4) bus.start = 1'b0;
    end
    check("flush_busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy_after", 64'(bus.busy), 64'd0);
    check("flush_hi", 64'(bus.hi), 64'(m_hi));
    check("flush_lo", 64'(bus.lo), 64'(m_lo));
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("flush_no_done", 64'(done_n), 64'd0);
    check("flush_hi_later", 64'(bus.hi), 64'(m_hi));

    // Reset in the middle of a divide clears everything immediately.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_done", 64'(bus.done), 64'd0);
    check("rst_mid_hi", 64'(bus.hi), 64'd0);
    check("rst_mid_lo", 64'(bus.lo), 64'd0);
    reset = 1'b1;
    run_arith("after_rst", OP_DIVU, 32'd1000, 32'd7, 1'b0);

    // Randomized operations interleaved with HI/LO moves.
    for (int k = 0; k < 16; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if (k % 4 == 0) ra = -32'($urandom_range(0, 1000));
      run_arith("rand", rop, ra, rb, (k % 3 == 0));
      if (k % 5 == 0) run_move("rand_mv", 3'($urandom_range(4, 7)), $urandom, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
